// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave port.
//   spi_mode_t  : frame mode latched at frame start (cpol, cpha, msb_first)
//   spi_state_t : frame tracking state
//   out_bit / shift_out / shift_in : bit-order aware shift helpers
package spi_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic msb_first;
  } spi_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } spi_state_t;

  // Bit that goes onto MISO next.
  function automatic logic out_bit(input logic [BYTE_W-1:0] b, input logic msb_first);
    return msb_first ? b[BYTE_W-1] : b[0];
  endfunction

  // Drop the bit just driven.
  function automatic logic [BYTE_W-1:0] shift_out(input logic [BYTE_W-1:0] b,
                                                  input logic msb_first);
    return msb_first ? {b[BYTE_W-2:0], 1'b0} : {1'b0, b[BYTE_W-1:1]};
  endfunction

  // MSB-first fills from the LSB upward; LSB-first fills from the MSB downward.
  function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] b,
                                                 input logic bit_in,
                                                 input logic msb_first);
    return msb_first ? {b[BYTE_W-2:0], bit_in} : {bit_in, b[BYTE_W-1:1]};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered edge pulses.
//   clk, nrst : system clock, async active-low reset
//   d         : asynchronous input
//   q         : synchronized level
//   rise/fall : one-cycle pulses, one register after q changes
module spi_sync_edge #(
  parameter int unsigned DEPTH   = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [DEPTH-1:0] chain;
  logic             prev;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      chain <= {DEPTH{RST_VAL}};
      prev  <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[DEPTH-2:0], d};
      prev  <= chain[DEPTH-1];
      rise  <= chain[DEPTH-1] & ~prev;
      fall  <= ~chain[DEPTH-1] & prev;
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/spi_slave_port.sv
// Byte-oriented SPI slave, oversampled in the clk domain.
//   spi_clk/spi_mosi/spi_cs_n : async pins from the master
//   spi_miso, spi_miso_oe     : serial data back, enabled while in a frame
//   cpol/cpha/msb_first       : mode, latched at frame start
//   tx_data/tx_valid/tx_ready : one-entry TX holding register
//   rx_data/rx_valid/rx_ready : RX output register
//   rx_overrun, tx_underrun   : one-cycle error pulses
//   frame_active              : synchronized, inverted spi_cs_n
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              msb_first,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              frame_active
);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_bit;

  spi_sync_edge #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .nrst(nrst), .d(spi_clk),
    .q(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .nrst(nrst), .d(spi_cs_n),
    .q(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) mosi_sync <= '0;
    else       mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_bit = mosi_sync[SYNC_STAGES-1];

  spi_state_t            state_q, state_d;
  spi_mode_t             mode_q;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0]     rx_shift, tx_shift, tx_hold;
  logic                  tx_full, first_byte;

  logic lead_edge, trail_edge, sample_edge, shift_edge, byte_done, load_req;
  logic [BYTE_W-1:0] rx_next, load_byte, shift_src;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Frame edges win over a same-cycle clock edge.
  always_comb begin
    state_d = state_q;
    if (cs_fall)      state_d = ST_FRAME;
    else if (cs_rise) state_d = ST_IDLE;
  end

  always_comb begin
    lead_edge   = 1'b0;
    trail_edge  = 1'b0;
    if (state_q == ST_FRAME && !cs_fall && !cs_rise) begin
      lead_edge  = mode_q.cpol ? sclk_fall : sclk_rise;
      trail_edge = mode_q.cpol ? sclk_rise : sclk_fall;
    end
    sample_edge = mode_q.cpha ? trail_edge : lead_edge;
    shift_edge  = mode_q.cpha ? lead_edge  : trail_edge;
    byte_done   = sample_edge && (bit_cnt == '1);
    rx_next     = shift_in(rx_shift, mosi_bit, mode_q.msb_first);
    load_byte   = tx_full ? tx_hold : IDLE_BYTE;
    // cpha=0 reloads at the wrap; cpha=1 reloads on the leading edge that
    // starts every byte after the first (the first came from frame start).
    load_req    = cs_fall
               || (byte_done && !mode_q.cpha)
               || (shift_edge && mode_q.cpha && bit_cnt == '0 && !first_byte);
    shift_src   = (mode_q.cpha && bit_cnt == '0 && !first_byte) ? load_byte : tx_shift;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mode_q      <= '0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_hold     <= '0;
      tx_full     <= 1'b0;
      first_byte  <= 1'b0;
      spi_miso    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;

      if (load_req) begin
        if (tx_full) tx_full     <= 1'b0;
        else         tx_underrun <= 1'b1;
      end
      if (tx_valid && !tx_full) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end

      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end

      if (cs_fall) begin
        mode_q     <= '{cpol: cpol, cpha: cpha, msb_first: msb_first};
        bit_cnt    <= '0;
        rx_shift   <= '0;
        first_byte <= 1'b1;
        if (cpha) begin
          tx_shift <= load_byte;
        end else begin
          spi_miso <= out_bit(load_byte, msb_first);
          tx_shift <= shift_out(load_byte, msb_first);
        end
      end else if (cs_rise) begin
        bit_cnt  <= '0;
        spi_miso <= 1'b1;
      end else begin
        if (sample_edge) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 3'd1;
          // Whole byte parked; the following trailing edge drives its first bit.
          if (byte_done && !mode_q.cpha) tx_shift <= load_byte;
        end
        if (shift_edge) begin
          first_byte <= 1'b0;
          spi_miso   <= out_bit(shift_src, mode_q.msb_first);
          tx_shift   <= shift_out(shift_src, mode_q.msb_first);
        end
      end
    end
  end

  assign tx_ready     = ~tx_full;
  assign spi_miso_oe  = (state_q == ST_FRAME);
  assign frame_active = ~cs_level;

endmodule

// File: tb/tb_spi_slave_port.sv
module tb_spi_slave_port;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, msb_first = 1'b1;
  logic       spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       rx_overrun, tx_underrun, frame_active;

  always #5 clk = ~clk;

  spi_slave_port #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .nrst(nrst), .cpol(cpol), .cpha(cpha), .msb_first(msb_first),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .frame_active(frame_active)
  );

  int n_cmp = 0, n_bad = 0;
  int exp_unr = 0, exp_ovr = 0, seen_unr = 0, seen_ovr = 0;
  bit rx_rand = 1'b0;

  logic [7:0] rx_exp[$];    // bytes the RX port must deliver, in order
  logic [7:0] supply[$];    // model of TX bytes not yet loaded for shifting
  logic [7:0] fq[$];        // bytes the feeder still has to write
  logic [7:0] mosi_q[$];    // bytes the master sends this frame
  logic [7:0] miso_exp[$];  // bytes the master must read this frame

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input logic [7:0] b, input int k, input logic msbf);
    return msbf ? b[7-k] : b[k];
  endfunction

  task automatic give_tx(input logic [7:0] b);
    fq.push_back(b);
    supply.push_back(b);
  endtask

  // Each load takes the oldest supplied byte, or the idle byte with an underrun.
  task automatic model_loads(input int n);
    for (int i = 0; i < n; i++) begin
      if (supply.size() > 0) miso_exp.push_back(supply.pop_front());
      else begin
        miso_exp.push_back(8'hFF);
        exp_unr++;
      end
    end
  endtask

  // TX feeder: keeps the holding register filled from fq.
  initial begin
    bit acc;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      acc = nrst && tx_valid && tx_ready;
      @(posedge clk);
      #1;
      if (acc && fq.size() > 0) void'(fq.pop_front());
      tx_valid = (fq.size() > 0);
      tx_data  = (fq.size() > 0) ? fq[0] : 8'h00;
    end
  end

  // Random RX back-pressure.
  initial forever begin
    @(posedge clk);
    #1;
    if (rx_rand) rx_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: RX scoreboard and error pulse counters.
  always @(negedge clk) begin
    if (nrst) begin
      if (rx_overrun === 1'b1) seen_ovr++;
      if (tx_underrun === 1'b1) seen_unr++;
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
        if (rx_exp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_unexpected: got %0h, expected no byte", rx_data);
        end else begin
          check("rx_data", rx_data, rx_exp.pop_front());
        end
      end
    end
  end

  // One frame from the master side; nbits need not be a multiple of 8.
  task automatic run_frame(input logic pol, input logic pha, input logic msbf,
                           input int nbits, input bit hold_rx, input bit scramble);
    int loads, full;
    logic [7:0] got;
    logic sbit;
    got   = 8'h00;
    full  = nbits / 8;
    loads = pha ? 1 + ((nbits > 0) ? (nbits - 1) / 8 : 0) : 1 + nbits / 8;
    miso_exp.delete();
    model_loads(loads);
    for (int b = 0; b < full; b++) begin
      if (!hold_rx || b == 0) rx_exp.push_back(mosi_q[b]);
      else exp_ovr++;
    end

    cpol = pol; cpha = pha; msb_first = msbf; spi_clk = pol;
    wait_clk(4 * H);
    spi_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (!pha) begin
        if (i == 0) spi_mosi = pick(mosi_q[0], 0, msbf);
        wait_clk(H);
        if (i == 0) begin
          check("oe_in_frame", spi_miso_oe, 1);
          check("frame_active", frame_active, 1);
          if (scramble) begin cpol = ~pol; cpha = ~pha; msb_first = ~msbf; end
        end
        sbit = spi_miso;
        spi_clk = ~pol;
        wait_clk(H);
        spi_clk = pol;
        if (i + 1 < nbits) spi_mosi = pick(mosi_q[(i + 1) / 8], (i + 1) % 8, msbf);
      end else begin
        wait_clk(H);
        if (i == 0) begin
          check("oe_in_frame", spi_miso_oe, 1);
          check("frame_active", frame_active, 1);
          if (scramble) begin cpol = ~pol; cpha = ~pha; msb_first = ~msbf; end
        end
        spi_clk = ~pol;
        spi_mosi = pick(mosi_q[i / 8], i % 8, msbf);
        wait_clk(H);
        sbit = spi_miso;
        spi_clk = pol;
      end
      got = msbf ? {got[6:0], sbit} : {sbit, got[7:1]};
      if (i % 8 == 7) check("miso_byte", got, miso_exp[i / 8]);
    end
    wait_clk(H);
    spi_cs_n = 1'b1;
    wait_clk(4 * H);
    check("miso_idle", spi_miso, 1);
    check("oe_idle", spi_miso_oe, 0);
    check("frame_idle", frame_active, 0);
    if (!hold_rx) begin
      for (int t = 0; t < 400 && rx_exp.size() > 0; t++) wait_clk(1);
      check("rx_drain", rx_exp.size(), 0);
      rx_exp.delete();
    end
    check("underrun_cnt", seen_unr, exp_unr);
    check("overrun_cnt", seen_ovr, exp_ovr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(3);
    check("rst_miso", spi_miso, 1);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame", frame_active, 0);
    nrst = 1'b1;
    wait_clk(4);

    // Mode 0, MSB first.
    give_tx(8'h3C);
    mosi_q = '{8'hA5};
    run_frame(1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0);

    // Mode 3, LSB first, two bytes each way.
    give_tx(8'h12); give_tx(8'h34);
    mosi_q = '{8'h81, 8'h7E};
    run_frame(1'b1, 1'b1, 1'b0, 16, 1'b0, 1'b0);

    // No TX byte: idle byte and one underrun.
    mosi_q = '{8'h96};
    run_frame(1'b1, 1'b1, 1'b1, 8, 1'b0, 1'b0);

    // Overrun with RX held off.
    rx_ready = 1'b0;
    mosi_q = '{8'h11, 8'h22};
    run_frame(1'b1, 1'b1, 1'b1, 16, 1'b1, 1'b0);
    check("ovr_rx_valid", rx_valid, 1);
    check("ovr_rx_data", rx_data, 8'h11);
    rx_ready = 1'b1;
    wait_clk(3);
    check("ovr_released", rx_valid, 0);
    check("ovr_drain", rx_exp.size(), 0);

    // Mode 1: 5-bit partial frame, then a full one.
    mosi_q = '{8'hA7};
    run_frame(1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b0);
    mosi_q = '{8'hC3};
    run_frame(1'b0, 1'b1, 1'b1, 8, 1'b0, 1'b0);

    // Reset mid-byte.
    cpol = 1'b0; cpha = 1'b0; msb_first = 1'b1; spi_clk = 1'b0;
    wait_clk(4 * H);
    miso_exp.delete();
    model_loads(1);
    spi_cs_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_clk(H); spi_clk = 1'b1; spi_mosi = ~spi_mosi;
      wait_clk(H); spi_clk = 1'b0;
    end
    check("pre_rst_unr", seen_unr, exp_unr);
    wait_clk(2);
    nrst = 1'b0;
    #1;
    check("mid_rst_miso", spi_miso, 1);
    check("mid_rst_oe", spi_miso_oe, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_ovr", rx_overrun, 0);
    check("mid_rst_unr", tx_underrun, 0);
    check("mid_rst_frame", frame_active, 0);
    supply.delete();
    fq.delete();
    wait_clk(3);
    spi_cs_n = 1'b1;
    wait_clk(4);
    nrst = 1'b1;
    wait_clk(4);
    give_tx(8'hE1);
    mosi_q = '{8'h5A};
    run_frame(1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0);

    // Randomized frames with mode inputs disturbed mid-frame.
    rx_rand = 1'b1;
    for (int f = 0; f < 10; f++) begin
      int nb, ns;
      logic p, h, m;
      nb = $urandom_range(1, 3);
      ns = $urandom_range(0, nb + 1);
      p = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      for (int s = 0; s < ns; s++) give_tx(8'($urandom));
      mosi_q.delete();
      for (int b = 0; b < nb; b++) mosi_q.push_back(8'($urandom));
      run_frame(p, h, m, 8 * nb, 1'b0, 1'b1);
    end
    rx_rand = 1'b0;
    rx_ready = 1'b1;
    wait_clk(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_port.md
# spi_slave_port

Byte-oriented SPI slave that sits directly downstream of `axi_spi` on the SPI pins. It oversamples `spi_clk`, `spi_mosi` and `spi_cs_n` in the system clock domain and delivers received bytes on a valid/ready port. It also shifts transmit bytes out on `spi_miso`. It serves as the on-chip peer for loopback and bring-up of the SPI master, supporting all four CPOL/CPHA modes and MSB/LSB-first order.

## Interface
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth on each SPI input; must be ≥2.
- `IDLE_BYTE`, default 8'hFF: byte shifted out when no TX byte is pending.
- `clk` in 1: system clock; the only clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `cpol`, `cpha`, `msb_first` in 1 each: mode; captured at frame start.
- `spi_clk`, `spi_mosi`, `spi_cs_n` in 1 each: asynchronous pins from the master.
- `spi_miso` out 1: serial data to the master.
- `spi_miso_oe` out 1: high while the frame is active.
- `tx_data` in 8, `tx_valid` in 1, `tx_ready` out 1: TX holding-register handshake.
- `rx_data` out 8, `rx_valid` out 1, `rx_ready` in 1: RX output register handshake.
- `rx_overrun`, `tx_underrun` out 1 each: single-cycle error pulses.
- `frame_active` out 1: synchronized, inverted `spi_cs_n`.

## Operation
- Each input passes through `SYNC_STAGES` flops. One further register detects edges of the synchronized `spi_clk` and `spi_cs_n`.
- Frame start is the detected falling edge of `spi_cs_n`. On that cycle:
  - `cpol`, `cpha` and `msb_first` are latched.
  - The bit counter is cleared.
  - The shift register is loaded from the TX holding register.
- Edge roles:
  - Leading edge is `spi_clk` leaving `cpol`; trailing edge is the return to `cpol`.
  - `cpha`=0: sample on leading, shift on trailing. Bit 0 of the byte is driven at frame start.
  - `cpha`=1: shift on leading (first shift drives bit 0), sample on trailing.
- Bit order: with `msb_first`=1, MISO sends bit 7 first and MOSI bits fill from the LSB upward. `msb_first`=0 mirrors this.
- Byte completion: the 8th sample completes a byte and the counter wraps to 0.
  - If the RX register is free, it is written and `rx_valid` rises.
  - If `rx_valid` is already set and `rx_ready` is low, the new byte is dropped, the old byte is kept, and `rx_overrun` pulses.
  - If `rx_ready` is high on that same cycle, the old byte is consumed and the new one loaded, with no overrun.
- Next byte load: the next byte comes from the TX holding register when the counter wraps (`cpha`=0) or at the next leading edge (`cpha`=1).
  - If the holding register is empty, `IDLE_BYTE` is shifted and `tx_underrun` pulses.
- TX holding register: one entry. `tx_ready` is high when empty, and `tx_valid && tx_ready` writes it. It empties when copied to the shift register.
- Frame end is the detected rising edge of `spi_cs_n`:
  - A partial byte is discarded, with no `rx_valid` and no error pulse.
  - The bit counter clears.
  - `spi_miso_oe` drops and `spi_miso` returns to 1.
  - TX holding and RX registers are untouched.
- Edges of `spi_clk` while `spi_cs_n` is high are ignored.
- The `spi_cs_n` edge takes priority over a same-cycle `spi_clk` edge.
- Mode inputs changed mid-frame have no effect until the next frame.

## Timing
- Reset values:
  - `spi_miso`=1
  - `spi_miso_oe`=0
  - `tx_ready`=1
  - `rx_valid`=0
  - `rx_data`=0
  - `rx_overrun`=0
  - `tx_underrun`=0
  - `frame_active`=0
  - Bit counter, shift registers and synchronizers all 0, except the `spi_cs_n` chain, which resets to 1.
- Pin-to-detect latency is `SYNC_STAGES`+1 clk cycles. `spi_miso` updates 1 clk after the detected shift edge, i.e. `SYNC_STAGES`+2 cycles after the pin edge.
- `rx_valid` asserts 1 clk after the detected 8th sample edge. It holds until `rx_valid && rx_ready`, then deasserts on the next cycle.
- Constraint on the master: `spi_clk` half-period ≥ `SYNC_STAGES`+4 clk cycles, and `spi_cs_n` setup/hold ≥ one `spi_clk` half-period. Behaviour outside this limit is undefined but must not lock up: the next frame start recovers.
- Reset asserted mid-frame forces the reset values immediately, with no pulse outputs.

## Structure
- Shared package `spi_pkg` holds:
  - `spi_mode_t`: packed `cpol`/`cpha`/`msb_first`.
  - `localparam BYTE_W = 8`.
  - `localparam BIT_CNT_W = 3`.
- Sub-module `spi_sync_edge` (parameters: depth and reset value) provides the synchronizer plus rise/fall pulse outputs. It is instantiated for `spi_clk` and `spi_cs_n`; `spi_mosi` uses the synchronizer only.

## Test plan
- Mode 0, MSB-first, half-period 8 clk; preload TX 8'h3C; master sends 8'hA5 → `rx_data`=8'hA5 with one `rx_valid`; master receives 8'h3C.
- Mode 3, LSB-first; two-byte frame with 8'h81, 8'h7E, TX 8'h12, 8'h34 written back-to-back → RX sequence 8'h81, 8'h7E; master reads 8'h12, 8'h34; no error pulses.
- No TX byte written; master sends one byte → master reads 8'hFF; one `tx_underrun` pulse at byte load.
- `rx_ready` held 0; master sends 8'h11 then 8'h22 → `rx_data` stays 8'h11; one `rx_overrun`; after `rx_ready`, `rx_valid` drops.
- Mode 1; `spi_cs_n` deasserted after 5 bits, then a full frame with 8'hC3 → no RX from the partial byte; next RX is 8'hC3; `spi_miso`=1 and `spi_miso_oe`=0 between frames.
- `nrst` pulsed low mid-byte → all outputs at reset values within the reset cycle; the following frame with 8'h5A receives correctly.
